// File: rtl/raster_engine.sv
// raster_engine
//   Shape rasterizer that sits after the draw controller. A one-cycle trigger
//   latches a shape command; the engine then walks the covered pixels in
//   raster order (y outer, x inner, both ascending) and emits one pixel write
//   per valid/ready handshake. A one-cycle r_done pulse marks completion.
//
//   Shapes: 0 point at (x0,y0), 1 filled rectangle, 2 rectangle outline,
//           3 reserved (completes immediately, no pixels).
//
//   Optional feature macro: RASTER_CLIP_EN
//     When defined, cursor positions with x >= WIDTH or y >= HEIGHT are still
//     visited (one cycle each) but presented with pix_valid low.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   trigger             start pulse, sampled only in IDLE
//   shape, x0/y0/x1/y1  shape command and corner coordinates (unsigned)
//   color               pixel colour
//   pix_valid/pix_ready pixel write handshake
//   pix_x/pix_y/pix_color pixel write payload
//   r_done              one-cycle completion pulse
//   r_busy              high whenever the engine is not IDLE
module raster_engine #(
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int CW     = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger,
    input  logic [1:0]    shape,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] color,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_color,
    output logic          r_done,
    output logic          r_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One extra bit so the screen limits compare cleanly against the cursor.
    localparam logic [XW:0] WIDTH_L  = (XW+1)'(WIDTH);
    localparam logic [YW:0] HEIGHT_L = (YW+1)'(HEIGHT);

    state_t        state_q, state_d;
    logic [1:0]    shape_q, shape_d;
    logic [XW-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [YW-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [CW-1:0] color_q, color_d;
    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, cx_q, cx_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d, cy_q, cy_d;

    logic visible;
    logic advance;

`ifdef RASTER_CLIP_EN
    assign visible = ({1'b0, cx_q} < WIDTH_L) && ({1'b0, cy_q} < HEIGHT_L);
`else
    logic unused_dims;
    assign unused_dims = ^{WIDTH_L, HEIGHT_L};
    assign visible     = 1'b1;
`endif

    // Clipped positions step without waiting for the writer.
    assign advance = (state_q == S_DRAW) && (pix_ready || !visible);

    assign pix_valid = (state_q == S_DRAW) && visible;
    assign pix_x     = cx_q;
    assign pix_y     = cy_q;
    assign pix_color = color_q;
    assign r_done    = (state_q == S_DONE);
    assign r_busy    = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        shape_d = shape_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    shape_d = shape;
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    color_d = color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // A point is drawn as a degenerate 1x1 rectangle at (x0,y0).
                if (shape_q == 2'd0) begin
                    xmin_d = x0_q;
                    xmax_d = x0_q;
                    ymin_d = y0_q;
                    ymax_d = y0_q;
                end else begin
                    xmin_d = (x0_q < x1_q) ? x0_q : x1_q;
                    xmax_d = (x0_q < x1_q) ? x1_q : x0_q;
                    ymin_d = (y0_q < y1_q) ? y0_q : y1_q;
                    ymax_d = (y0_q < y1_q) ? y1_q : y0_q;
                end
                cx_d    = xmin_d;
                cy_d    = ymin_d;
                state_d = (shape_q == 2'd3) ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
                // End-of-row is tested before any increment, so coordinates
                // at their all-ones maximum never wrap.
                if (advance) begin
                    if (cx_q == xmax_q && cy_q == ymax_q) begin
                        state_d = S_DONE;
                    end else if (cx_q == xmax_q) begin
                        cx_d = xmin_q;
                        cy_d = cy_q + 1'b1;
                    end else if (shape_q == 2'd2 && cy_q != ymin_q &&
                                 cy_q != ymax_q && cx_q == xmin_q) begin
                        cx_d = xmax_q;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
        end
    end

    // Command and bounds registers are only read once the FSM has loaded them.
    always_ff @(posedge clk) begin
        shape_q <= shape_d;
        x0_q    <= x0_d;
        y0_q    <= y0_d;
        x1_q    <= x1_d;
        y1_q    <= y1_d;
        xmin_q  <= xmin_d;
        xmax_q  <= xmax_d;
        ymin_q  <= ymin_d;
        ymax_q  <= ymax_d;
    end

endmodule

// File: doc/raster_engine.md
# raster_engine

Shape rasterizer directly downstream of the draw controller. On a one-cycle `trigger` pulse it latches the shape command, walks the covered pixels in raster order and emits one pixel write per accepted handshake toward the framebuffer writer. When the last pixel is accepted it returns a one-cycle `r_done` pulse, which the controller uses to clear `busy`.

## Interface
- `XW`, 10, x-coordinate width (bits)
- `YW`, 9, y-coordinate width (bits)
- `CW`, 8, colour width (bits)
- `WIDTH`, 640, screen width in pixels; used only when clipping is compiled in
- `HEIGHT`, 480, screen height in pixels; used only when clipping is compiled in

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `trigger`  in  1  start pulse from the controller
- `shape`  in  2  shape code: 0 point, 1 filled rect, 2 rect outline, 3 reserved
- `x0`, `x1`  in  XW  corner x coordinates, unsigned
- `y0`, `y1`  in  YW  corner y coordinates, unsigned
- `color`  in  CW  pixel colour
- `pix_valid`  out  1  pixel write valid
- `pix_ready`  in  1  framebuffer writer accepts a pixel
- `pix_x`  out  XW  pixel x coordinate
- `pix_y`  out  YW  pixel y coordinate
- `pix_color`  out  CW  pixel colour
- `r_done`  out  1  one-cycle completion pulse
- `r_busy`  out  1  high whenever the state is not IDLE

## Operation
- **States:** IDLE, SETUP, DRAW, DONE.
- **IDLE:** when `trigger`=1, latch `shape`, `x0`, `y0`, `x1`, `y1` and `color`, then go to SETUP. `trigger` is ignored in every other state.
- **SETUP:**
  - Compute xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1).
  - Set the cursor to (xmin, ymin).
  - Shape 3: go to DONE. Otherwise go to DRAW.
- **Point:** emits exactly one pixel at (x0, y0). The second corner is ignored.
- **Filled rect:** emits every (x, y) with xmin≤x≤xmax and ymin≤y≤ymax. Order is y outer and ascending, x inner and ascending.
- **Outline:** same order as filled rect, restricted to pixels on the border.
  - On rows ymin and ymax, every x is emitted.
  - On interior rows, xmin is emitted, then the cursor jumps to xmax.
  - If xmin==xmax, the row ends after one pixel. No pixel is emitted twice.
- **DRAW handshake:**
  - `pix_valid`=1 and the cursor is presented on `pix_x`/`pix_y`.
  - The cursor advances only on `pix_valid && pix_ready`.
  - Outputs stay stable while stalled.
- **DRAW exit:** when the final pixel (xmax, ymax) is accepted (or the point is accepted), go to DONE.
- **DONE:** `r_done`=1 for exactly one cycle, then return to IDLE.
- **Arithmetic:** cursor compares and increments are done at XW/YW width. A coordinate at its all-ones maximum terminates correctly, with no wrap to 0.
- **Reset (`rst`=1):** state goes to IDLE and `pix_valid`, `r_done`, `r_busy` all go to 0. This applies mid-draw too; any in-flight pixel is dropped and no `r_done` is issued.

## Timing
- Reset values: `pix_valid`=0, `r_done`=0, `r_busy`=0. `pix_x`, `pix_y` and `pix_color` reset to 0.
- `trigger` is sampled high in cycle T:
  - SETUP and `r_busy`=1 from cycle T+1.
  - First `pix_valid` in cycle T+2.
- With `pix_ready` tied high, one pixel is accepted per cycle. For N emitted pixels, `r_done` is high in cycle T+2+N.
- Shape 3: `r_done` in cycle T+2. No `pix_valid` is ever asserted.
- `r_busy` falls in the cycle after `r_done`. A `trigger` in that cycle (IDLE) is accepted.
- `pix_ready` may toggle arbitrarily. Stall cycles add latency one-for-one.

## Configuration
- Macro `RASTER_CLIP_EN`.
- **Defined:** candidate pixels with x≥WIDTH or y≥HEIGHT are suppressed.
  - The cursor still visits them at one cycle each, with `pix_valid`=0 and no ready required.
  - A fully off-screen shape produces no pixels but still ends with `r_done`.
- **Undefined:** every candidate pixel is emitted. `WIDTH` and `HEIGHT` are unused.

## Test plan
- **Point:** shape 0, (5,7), colour 0xAA, ready high → exactly one pixel (5,7,0xAA) at T+2, `r_done` at T+3.
- **Filled rect, swapped corners:** shape 1, (3,2)-(0,0), ready high → 12 pixels in order (0,0),(1,0)…(3,2), `r_done` at T+14.
- **Outline:** shape 2, (0,0)-(3,3) → 12 pixels. Interior rows emit only x=0 and x=3. Zero duplicates.
- **Backpressure:** filled rect (0,0)-(1,0), `pix_ready` low for 3 cycles on the first pixel → pixel held stable; 2 pixels total; `r_done` at T+7.
- **Reset and retrigger:** `rst` mid-DRAW → next cycle `pix_valid`=0, `r_busy`=0, no `r_done`. A `trigger` pulse during DRAW in a separate run is ignored.
- **Clipping, with `RASTER_CLIP_EN`, WIDTH=640:** filled rect (638,0)-(641,0) → only x=638 and 639 emitted; `r_done` at T+6.
